id_stage_hazard: RTL
====================

Name: id_stage_hazard

Overview:
Parametrised instruction-decode stage for the 5-stage LEGv8 pipeline. It owns the IF/ID pipeline register, a register file with write-through bypass, immediate and branch-offset extraction, load-use hazard detection, and the ID/EX pipeline register. It sits between instruction fetch and execute. It replaces the purely combinational decode with a stall- and flush-aware stage.

Parameters:
DATA_W, 64, datapath and register width
REG_AW, 5, register address width; register count = 2**REG_AW
ZERO_REG, 31, register index that reads as 0 and ignores writes

Ports:
clk  in  1  clock
reset  in  1  reset
if_valid  in  1  fetched instruction is valid
if_instr  in  32  fetched instruction
if_pc  in  DATA_W  PC of fetched instruction
flush  in  1  branch taken; squash IF/ID and insert a bubble
ctl_reg2loc  in  1  0: second read address = Rd [4:0]; 1: Rm [20:16]
ctl_uncond_br  in  1  1: branch offset from [25:0]; 0: from [23:5]
ctl_mem_read  in  1  decoded instruction is a load
ctl_reg_write  in  1  decoded instruction writes Rd
wb_we  in  1  writeback enable
wb_rd  in  REG_AW  writeback register
wb_data  in  DATA_W  writeback data
id_instr  out  32  IF/ID instruction, fed to the external control unit
stall  out  1  hold PC and IF/ID
ex_valid  out  1  ID/EX holds a real instruction
ex_pc, ex_a, ex_b, ex_imm12, ex_daddr9, ex_br_off  out  DATA_W  registered decode results
ex_rn, ex_rm, ex_rd  out  REG_AW  registered register fields
ex_mem_read, ex_reg_write  out  1  registered controls

Behaviour:
- Reset is asynchronous and active-high, with one clock. While reset is asserted, IF/ID valid, instr and pc are 0. All ex_* outputs are 0. All registers in the register file are 0.
- IF/ID update priority: flush, then stall, then load. Flush clears valid and instr to 0. Stall holds the current contents. Otherwise IF/ID loads if_valid, if_instr and if_pc.
- Fields are taken from IF/ID: Rn = [9:5], Rm = [20:16], Rd = [4:0].
  - imm12 = [21:10], zero-extended.
  - daddr9 = [20:12], sign-extended.
  - br_off = ctl_uncond_br ? sext([25:0]) : sext([23:5]). The offset is in words and is not shifted.
- Second read address: ab = ctl_reg2loc ? Rm : Rd.
- Register file:
  - Write on posedge when wb_we=1 and wb_rd != ZERO_REG.
  - A read of ZERO_REG returns 0.
  - A read whose address equals wb_rd while wb_we=1 (wb_rd != ZERO_REG) returns wb_data in the same cycle. This is write-through bypass.
- Load-use hazard: stall = id_valid & ex_valid & ex_mem_read & (ex_rd != ZERO_REG) & (ex_rd == Rn | ex_rd == ab) & ~flush.
  - The hazard check is combinational.
  - The stall lasts exactly one cycle per load, because the next ID/EX contents are a bubble.
- ID/EX register, on each posedge:
  - When flush, stall or ~id_valid: load a bubble. ex_valid, ex_mem_read and ex_reg_write become 0; data fields keep their previous values.
  - Otherwise: load all decode results and ex_valid=1.
  - Latency from IF/ID to ex_* is one cycle.
- Simultaneous flush and stall: flush wins. stall output is 0, IF/ID is cleared, and ID/EX gets a bubble.
- Reset asserted mid-operation clears everything immediately. The first valid instruction after reset deasserts reaches ex_* two edges after it is presented on if_*.

Decomposition:
- Package id_pkg holds:
  - Field bit positions: RN_LSB=5, RM_LSB=16, IMM12_LSB=10, DADDR9_LSB=12, COND19_LSB=5.
  - Width constants.
  - A packed struct idex_t for the ID/EX bundle.
- One sub-module, regfile_bypass, parametrised by DATA_W and REG_AW. It has 2 read ports, 1 write port, ZERO_REG handling, write-through bypass and async reset clear.
- Hazard logic and pipeline registers live in the top module.

Test Plan:
- ADDI X0,X31,#0 (0x910003E0), then ADDI X1,X0,#1 (0x91000401), no writeback -> ex_imm12=0 then 1; ex_rn=31 then 0; ex_a=0; ex_valid=1 on the second and third edges.
- Bypass: wb_we=1, wb_rd=3, wb_data=0xDEAD in the same cycle IF/ID holds an instr with Rn=3 -> ex_a=0xDEAD on the next edge. With wb_rd=31, a read of X31 gives ex_a=0.
- B #2 (0x14000002) with ctl_uncond_br=1 -> ex_br_off=2. CBZ with [23:5]=0x7FFFF and ctl_uncond_br=0 -> ex_br_off=0xFFFF_FFFF_FFFF_FFFF.
- LDUR X2 (ctl_mem_read=1) followed by ADD with Rn=2 -> stall=1 for exactly one cycle, ex_valid=0 for one cycle, then the ADD appears with ex_rn=2. An ADD with Rn=5 after the LDUR -> no stall.
- Load-use condition and flush=1 in the same cycle -> stall=0, IF/ID cleared, next ex_valid=0.
- Reset asserted mid-stream with ex_valid=1 -> ex_* = 0 and stall=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared field positions, widths and ID/EX control bundle for the decode stage
package id_pkg;

    localparam int INSTR_W    = 32;

    // Instruction field positions (LEGv8 encodings)
    localparam int RD_LSB     = 0;
    localparam int RN_LSB     = 5;
    localparam int RM_LSB     = 16;
    localparam int IMM12_LSB  = 10;
    localparam int DADDR9_LSB = 12;
    localparam int COND19_LSB = 5;
    localparam int BR26_LSB   = 0;

    // Field widths
    localparam int IMM12_W    = 12;
    localparam int DADDR9_W   = 9;
    localparam int COND19_W   = 19;
    localparam int BR26_W     = 26;

    // Control half of the ID/EX register; these bits are zeroed on a bubble
    // while the data half keeps its previous contents.
    typedef struct packed {
        logic valid;
        logic mem_read;
        logic reg_write;
    } idex_t;

endpackage

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - 2R1W register file with hardwired zero register and write-through bypass
module regfile_bypass #(
    parameter int DATA_W   = 64,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    localparam int                NREG = 2 ** REG_AW;
    localparam logic [REG_AW-1:0] ZR   = REG_AW'(ZERO_REG);

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_live;

    // A write to the zero register is discarded, so it must not bypass either
    assign wr_live = we && (waddr != ZR);

    // Storage: cleared on reset, written on the rising edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[waddr] <= wdata;
        end
    end

    // Port A: zero register, then same-cycle writeback, then stored value
    always_comb begin
        rdata_a = regs[raddr_a];
        if (raddr_a == ZR) begin
            rdata_a = '0;
        end else if (wr_live && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
    end

    // Port B: same read rules as port A
    always_comb begin
        rdata_b = regs[raddr_b];
        if (raddr_b == ZR) begin
            rdata_b = '0;
        end else if (wr_live && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: rtl/id_stage_hazard.sv
// rtl/id_stage_hazard.sv - LEGv8 decode stage with IF/ID and ID/EX registers and load-use stall
module id_stage_hazard
    import id_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_valid,
    input  logic [31:0]         if_instr,
    input  logic [DATA_W-1:0]   if_pc,
    input  logic                flush,
    input  logic                ctl_reg2loc,
    input  logic                ctl_uncond_br,
    input  logic                ctl_mem_read,
    input  logic                ctl_reg_write,
    input  logic                wb_we,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [31:0]         id_instr,
    output logic                stall,
    output logic                ex_valid,
    output logic [DATA_W-1:0]   ex_pc,
    output logic [DATA_W-1:0]   ex_a,
    output logic [DATA_W-1:0]   ex_b,
    output logic [DATA_W-1:0]   ex_imm12,
    output logic [DATA_W-1:0]   ex_daddr9,
    output logic [DATA_W-1:0]   ex_br_off,
    output logic [REG_AW-1:0]   ex_rn,
    output logic [REG_AW-1:0]   ex_rm,
    output logic [REG_AW-1:0]   ex_rd,
    output logic                ex_mem_read,
    output logic                ex_reg_write
);

    localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

    logic              id_valid;
    logic [DATA_W-1:0] id_pc;
    logic [REG_AW-1:0] rn, rm, rd, ab;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic [DATA_W-1:0] imm12, daddr9, br_off;
    logic              bubble;
    idex_t             ex_ctl;

    assign rn = id_instr[RN_LSB +: REG_AW];
    assign rm = id_instr[RM_LSB +: REG_AW];
    assign rd = id_instr[RD_LSB +: REG_AW];
    assign ab = ctl_reg2loc ? rm : rd;

    // Immediates: imm12 unsigned, the rest two's-complement; offsets stay in words
    assign imm12  = DATA_W'(id_instr[IMM12_LSB +: IMM12_W]);
    assign daddr9 = {{(DATA_W-DADDR9_W){id_instr[DADDR9_LSB+DADDR9_W-1]}},
                     id_instr[DADDR9_LSB +: DADDR9_W]};
    assign br_off = ctl_uncond_br
                  ? {{(DATA_W-BR26_W){id_instr[BR26_LSB+BR26_W-1]}}, id_instr[BR26_LSB +: BR26_W]}
                  : {{(DATA_W-COND19_W){id_instr[COND19_LSB+COND19_W-1]}}, id_instr[COND19_LSB +: COND19_W]};

    regfile_bypass #(
        .DATA_W   (DATA_W),
        .REG_AW   (REG_AW),
        .ZERO_REG (ZERO_REG)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (rn),
        .raddr_b (ab),
        .rdata_a (rd_a),
        .rdata_b (rd_b),
        .we      (wb_we),
        .waddr   (wb_rd),
        .wdata   (wb_data)
    );

    // A load in EX whose destination feeds this instruction costs one bubble;
    // a taken branch squashes the consumer anyway, so flush suppresses it.
    assign stall = id_valid && ex_ctl.valid && ex_ctl.mem_read && (ex_rd != ZR) &&
                   ((ex_rd == rn) || (ex_rd == ab)) && !flush;

    assign bubble = flush || stall || !id_valid;

    // IF/ID register: flush beats stall beats load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid <= 1'b0;
            id_instr <= '0;
            id_pc    <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_instr <= '0;
        end else if (!stall) begin
            id_valid <= if_valid;
            id_instr <= if_instr;
            id_pc    <= if_pc;
        end
    end

    // ID/EX register: a bubble clears only the controls, data fields hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ctl    <= '0;
            ex_pc     <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_imm12  <= '0;
            ex_daddr9 <= '0;
            ex_br_off <= '0;
            ex_rn     <= '0;
            ex_rm     <= '0;
            ex_rd     <= '0;
        end else if (bubble) begin
            ex_ctl    <= '0;
        end else begin
            ex_ctl    <= '{valid: 1'b1, mem_read: ctl_mem_read, reg_write: ctl_reg_write};
            ex_pc     <= id_pc;
            ex_a      <= rd_a;
            ex_b      <= rd_b;
            ex_imm12  <= imm12;
            ex_daddr9 <= daddr9;
            ex_br_off <= br_off;
            ex_rn     <= rn;
            ex_rm     <= rm;
            ex_rd     <= rd;
        end
    end

    assign ex_valid     = ex_ctl.valid;
    assign ex_mem_read  = ex_ctl.mem_read;
    assign ex_reg_write = ex_ctl.reg_write;

endmodule
